yasac_ctrl: RTL

Control unit for the YASAC processor. It is a Moore/Mealy FSM that sequences the data unit (PC, IR, accumulator, ALU, data memory, I/O port bank) through fetch, decode and execute using the opcode and flags the data unit returns. It owns the external START/RDY handshake of the top-level `yasac` and instantiates beside `data_unit` inside it.

---
 rtl/yasac_pkg.sv | 48 ++++
 rtl/yasac_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/yasac_pkg.sv
// Shared definitions for the YASAC control unit: opcodes, datapath select encodings and FSM state encoding.
package yasac_pkg;

    localparam logic [3:0] OP_HALT = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ST   = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_IN   = 4'h6;
    localparam logic [3:0] OP_OUT  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_JC   = 4'hA;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_AND  = 2'd2;
    localparam logic [1:0] ALU_PASS = 2'd3;

    localparam logic [1:0] ACC_SRC_ALU  = 2'd0;
    localparam logic [1:0] ACC_SRC_MEM  = 2'd1;
    localparam logic [1:0] ACC_SRC_PORT = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEMRD  = 3'd4,
        ST_HALT   = 3'd5,
        ST_WAIT   = 3'd6
    } state_e;

    // Instructions that need the extra MEMRD cycle to pick up their operand.
    function automatic logic needsMemRead(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

    function automatic logic [1:0] aluOpFor(input logic [3:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/yasac_ctrl.sv
// YASAC control unit: fetch/decode/execute sequencer driving the data unit strobes.
// Define YASAC_STEP_EN to insert a single-step WAIT state before every FETCH after the first.
module yasac_ctrl
    import yasac_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic       STEP,
    input  logic [3:0] OPCODE,
    input  logic       ZF,
    input  logic       CF,
    output logic       RDY,
    output logic       PC_CLR,
    output logic       PC_INC,
    output logic       PC_LD,
    output logic       IR_LD,
    output logic       ADDR_SEL,
    output logic       MEM_WE,
    output logic       PORT_WE,
    output logic       ACC_LD,
    output logic [1:0] ACC_SRC,
    output logic [1:0] ALU_OP,
    output logic       FLAG_LD,
    output logic [2:0] STATE
);

    state_e stateQ, stateD;

`ifdef YASAC_STEP_EN
    localparam state_e NEXT_INSTR = ST_WAIT;
`else
    localparam state_e NEXT_INSTR = ST_FETCH;
    logic unusedStep;
    assign unusedStep = STEP;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stateQ <= ST_IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Strobes are decoded from the current state so that reset clears them without waiting for an edge.
    always_comb begin
        stateD   = stateQ;
        RDY      = 1'b0;
        PC_CLR   = 1'b0;
        PC_INC   = 1'b0;
        PC_LD    = 1'b0;
        IR_LD    = 1'b0;
        ADDR_SEL = 1'b0;
        MEM_WE   = 1'b0;
        PORT_WE  = 1'b0;
        ACC_LD   = 1'b0;
        ACC_SRC  = ACC_SRC_ALU;
        ALU_OP   = ALU_ADD;
        FLAG_LD  = 1'b0;

        case (stateQ)
            ST_IDLE, ST_HALT: begin
                RDY = 1'b1;
                if (START) begin
                    PC_CLR = 1'b1;
                    stateD = ST_FETCH;
                end
            end

            ST_FETCH: begin
                IR_LD  = 1'b1;
                stateD = ST_DECODE;
            end

            ST_DECODE: begin
                PC_INC = 1'b1;
                stateD = (OPCODE == OP_HALT) ? ST_HALT : ST_EXEC;
            end

            ST_EXEC: begin
                stateD = NEXT_INSTR;
                case (OPCODE)
                    OP_LD, OP_ADD, OP_SUB, OP_AND: begin
                        ADDR_SEL = 1'b1;
                        stateD   = ST_MEMRD;
                    end
                    OP_ST: begin
                        ADDR_SEL = 1'b1;
                        MEM_WE   = 1'b1;
                    end
                    OP_IN: begin
                        ADDR_SEL = 1'b1;
                        ACC_SRC  = ACC_SRC_PORT;
                        ACC_LD   = 1'b1;
                    end
                    OP_OUT: begin
                        ADDR_SEL = 1'b1;
                        PORT_WE  = 1'b1;
                    end
                    OP_JMP:  PC_LD = 1'b1;
                    OP_JZ:   PC_LD = ZF;
                    OP_JC:   PC_LD = CF;
                    default: ;
                endcase
            end

            // IR still holds the instruction, so OPCODE selects between LD and the ALU ops here.
            ST_MEMRD: begin
                ACC_LD = 1'b1;
                stateD = NEXT_INSTR;
                if (OPCODE == OP_LD) begin
                    ACC_SRC = ACC_SRC_MEM;
                end else if (needsMemRead(OPCODE)) begin
                    ACC_SRC = ACC_SRC_ALU;
                    ALU_OP  = aluOpFor(OPCODE);
                    FLAG_LD = 1'b1;
                end
            end

`ifdef YASAC_STEP_EN
            ST_WAIT: begin
                if (STEP) begin
                    stateD = ST_FETCH;
                end
            end
`endif

            default: stateD = ST_IDLE;
        endcase
    end

    assign STATE = stateQ;

endmodule
